// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win by default, a starvation counter
// forces write-side slots through, and a built-in engine can fill the screen.
module vram_arbiter #(
    parameter int AW           = 19,
    parameter int DW           = 8,
    parameter int DEPTH        = 307200,
    parameter int STARVE_LIMIT = 16,
    parameter int RD_LAT       = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          starve_evt
);

    // state | meaning
    // IDLE  | write side served by the external pixel writer
    // FILL  | write side served by the fill engine, writer stalled
    typedef enum logic {IDLE, FILL} state_t;

    localparam int            CW    = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    state_t            state, state_nx;
    logic [AW-1:0]     fill_addr;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     color;
    logic [CW-1:0]     starve_cnt;
    logic [RD_LAT-1:0] rv_pipe;
    logic              wp, force_wr, wr_grant, rd_grant;

    // All grants are suppressed while clr is low so reset produces no RAM traffic.
    always_comb begin
        state_nx   = state;
        wp         = 1'b0;
        force_wr   = 1'b0;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        disp_ack   = 1'b0;
        wr_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_din    = '0;
        starve_evt = 1'b0;
        fill_busy  = 1'b0;
        if (clr) begin
            fill_busy  = (state == FILL);
            wp         = (state == FILL) ? 1'b1 : wr_valid;
            force_wr   = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
            wr_grant   = wp && (!disp_req || force_wr);
            rd_grant   = !wr_grant && disp_req;
            starve_evt = force_wr && disp_req;
            if (rd_grant) begin
                disp_ack = 1'b1;
                ram_addr = disp_addr;
            end else if (wr_grant) begin
                ram_we = 1'b1;
                if (state == FILL) begin
                    ram_addr = fill_addr;
                    ram_din  = color;
                end else begin
                    ram_addr = wr_addr;
                    ram_din  = wr_data;
                    wr_ready = 1'b1;
                end
            end
            case (state)
                IDLE:    if (fill_start) state_nx = FILL;
                FILL:    if (wr_grant && fill_addr == LAST) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            fill_addr  <= '0;
            addr_q     <= '0;
            color      <= '0;
            starve_cnt <= '0;
            rv_pipe    <= '0;
        end else begin
            addr_q  <= ram_addr;
            rv_pipe <= (rv_pipe << 1) | RD_LAT'(disp_ack);
            if (state == IDLE && fill_start) begin
                color     <= fill_color;
                fill_addr <= '0;
            end else if (state == FILL && wr_grant) begin
                fill_addr <= fill_addr + 1'b1;
            end
            if (!wp || wr_grant)
                starve_cnt <= '0;
            else if (disp_req && !force_wr && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign disp_rvalid = rv_pipe[RD_LAT-1];
    assign disp_rdata  = ram_dout;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single VRAM port and shares it among three sources: the VGA scan-out fetch (read), a pixel writer (write), and a built-in screen-fill engine.
- Sits between vga640x480, the drawing logic and the vram instance, in the dclk domain.
- Display reads have priority. A starvation limit guarantees that writes make progress.
- Handshakes are valid/ack on both requester sides. Read data returns a fixed latency after the grant.

Parameters:
- AW, 19, VRAM address width.
- DW, 8, pixel width (3R/3G/2B).
- DEPTH, 307200, number of pixels (640x480). The fill engine covers addresses 0..DEPTH-1.
- STARVE_LIMIT, 16, number of consecutive denied write-side cycles before the write side is forced through. 0 disables forcing.
- RD_LAT, 1, VRAM read latency in cycles.

Ports:
- clk, in, 1, pixel clock (dclk).
- clr, in, 1, reset. Synchronous, active-low.
- disp_req, in, 1, display read request. Held until disp_ack.
- disp_addr, in, AW, display read address.
- disp_ack, out, 1, read granted this cycle.
- disp_rvalid, out, 1, disp_rdata valid. Asserts RD_LAT cycles after disp_ack.
- disp_rdata, out, DW, read data (ram_dout passthrough).
- wr_valid, in, 1, writer request. Held with address/data until wr_ready.
- wr_addr, in, AW, write address.
- wr_data, in, DW, write data.
- wr_ready, out, 1, write accepted this cycle.
- fill_start, in, 1, start a whole-screen fill (pulse).
- fill_color, in, DW, fill value. Sampled on the accepted fill_start.
- fill_busy, out, 1, fill in progress.
- ram_we, out, 1, VRAM write enable (wea).
- ram_addr, out, AW, VRAM address (addra).
- ram_din, out, DW, VRAM write data.
- ram_dout, in, DW, VRAM read data.
- starve_evt, out, 1, one-cycle pulse when a forced write slot overrides a display request.

Behaviour:
- Reset (clr=0 at a clk edge):
  - All outputs are 0: disp_ack, disp_rvalid, wr_ready, fill_busy, ram_we, ram_addr, ram_din, starve_evt.
  - FSM goes to IDLE. Fill address, starvation counter and rvalid pipeline are cleared.
  - Reset mid-fill aborts the fill; the partially filled VRAM is left as is.
- FSM states:
  - IDLE:
    - Write-side source is the external writer.
    - fill_start=1 latches fill_color, sets fill_addr=0 and moves to FILL.
  - FILL:
    - Write-side source is the fill engine; wr_ready is held 0.
    - Each granted write slot writes fill_color to fill_addr, then increments fill_addr.
    - The slot that writes DEPTH-1 returns the FSM to IDLE on the next edge.
    - fill_busy=1 throughout FILL.
    - fill_start is ignored while in FILL.
- Write-side pending (wp):
  - In IDLE, wp = wr_valid.
  - In FILL, wp = 1.
- Arbitration (combinational, per cycle):
  - force = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - Write slot granted when wp && (!disp_req || force). Otherwise, if disp_req, a read slot is granted. At most one grant per cycle.
- Read slot:
  - disp_ack=1, ram_we=0, ram_addr=disp_addr.
- Write slot:
  - ram_we=1, with ram_addr/ram_din from the active source.
  - In IDLE, wr_ready=1.
- Idle cycle (no grant):
  - ram_we=0.
  - ram_addr holds its last value.
- Output timing: ram_* and ack/ready are combinational from the same-cycle grant. No write is ever issued without an ack/ready to its source in that cycle (fill is internal).
- disp_rvalid: an RD_LAT-deep shift register of disp_ack. disp_rdata = ram_dout unconditionally; it is meaningful only while disp_rvalid=1.
- Starvation counter (saturates at STARVE_LIMIT):
  - Increments when wp && disp_req && !force.
  - Clears on any write grant and whenever wp=0.
  - starve_evt = force && disp_req.
  - On a forced cycle the display is not acked and must hold its request.
- Simultaneous events:
  - fill_start with wr_valid in IDLE on the same cycle: that cycle's write-side source is still the writer. FILL begins next cycle.
  - A writer still pending after FILL begins stalls until IDLE, so its write lands after the fill.
- Width rules:
  - fill_addr is AW bits, compared to DEPTH-1. It never wraps.
  - An external wr_addr >= DEPTH is passed through unchecked.

Test Plan:
- Reset: hold clr=0 with all requests asserted for 3 cycles -> every output 0, no ram_we pulses. Release -> arbitration resumes on the first cycle.
- Read latency: disp_req=1, addr=0x00100, ram model returns addr[7:0] -> disp_ack same cycle, disp_rvalid=1 with rdata=0x00 exactly 1 cycle later. Back-to-back reads give one ack per cycle.
- Priority/starvation: disp_req held 1 continuously, wr_valid=1 addr=5 data=0xE0, STARVE_LIMIT=16 -> 16 cycles of disp_ack, then on cycle 17 ram_we=1, wr_ready=1, starve_evt=1, disp_ack=0. Counter clears and the pattern repeats for the next write.
- Idle write: disp_req=0, wr_valid=1 -> wr_ready and ram_we on the same cycle, ram_addr/din equal to wr_addr/wr_data.
- Fill: DEPTH=8 override, fill_start with color 0x1C, no display traffic -> fill_busy for 8 cycles, addresses 0..7 written with 0x1C, then IDLE. A fill_start pulse mid-fill is ignored. A wr_valid during the fill is accepted only after fill_busy falls.
- Reset mid-fill at address 3 -> fill_busy=0 on the next edge, no further writes. A new fill_start restarts at address 0.
